// File: rtl/app_switcher_pkg.sv
// Shared types and helpers for the frame-synchronous application switcher.
package app_switcher_pkg;

    // Switcher FSM states.
    typedef enum logic [1:0] {
        StRun,
        StWaitFrame,
        StBlank
    } state_e;

    // All segments off on active-low HEX displays.
    localparam logic [7:0] HexOffDefault = 8'hFF;

    // Low bit index of slice idx in a bus of equally sized slices.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sel_debouncer.sv
// Two-flop synchroniser followed by a stable-value debouncer for the app selection.
module sel_debouncer
    import app_switcher_pkg::*;
#(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] req
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;

    // Synchronise, then accept a new value once it has held for STABLE_CYCLES samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q == acc_q) begin
                cnt_q <= '0;
            end else if ((sync2_q != cand_q) || (cnt_q == '0)) begin
                // First sample of a new candidate value.
                cand_q <= sync2_q;
                if (CntW'(STABLE_CYCLES) == CntW'(1)) begin
                    acc_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= CntW'(1);
                end
            end else if ((cnt_q + CntW'(1)) == CntW'(STABLE_CYCLES)) begin
                acc_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign req = acc_q;

endmodule

// File: rtl/app_switcher.sv
// Frame-synchronous selector between display applications with blanking on each switch.
module app_switcher
    import app_switcher_pkg::*;
#(
    parameter int unsigned NUM_APPS      = 3,
    parameter int unsigned SEL_W         = (NUM_APPS > 2) ? $clog2(NUM_APPS) : 1,
    parameter int unsigned COLOR_W       = 12,
    parameter int unsigned LED_W         = 10,
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned BLANK_FRAMES  = 2,
    parameter logic [7:0]  HEX_OFF       = HexOffDefault
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pause,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic [9:0]                  sel,
    input  logic [NUM_APPS*COLOR_W-1:0] out_bus,
    input  logic [NUM_APPS*LED_W-1:0]   led_bus,
    input  logic [NUM_APPS*32-1:0]      hex_bus,
    output logic [COLOR_W-1:0]          out,
    output logic [LED_W-1:0]            LED,
    output logic [7:0]                  HEX0,
    output logic [7:0]                  HEX1,
    output logic [7:0]                  HEX2,
    output logic [7:0]                  HEX3,
    output logic [NUM_APPS-1:0]         app_pause,
    output logic [SEL_W-1:0]            active,
    output logic                        switching
);

    localparam int unsigned BlankW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

    state_e            state_q;
    logic [SEL_W-1:0]  active_q;
    logic [SEL_W-1:0]  pending_q;
    logic [BlankW-1:0] blank_cnt_q;
    logic              origin_q;
    logic              origin_prev_q;
    logic              frame_start;

    logic [9:0]        req;
    logic              req_valid;
    logic              req_new;
    logic [SEL_W-1:0]  req_idx;

    logic [COLOR_W-1:0] color_arr [NUM_APPS];
    logic [LED_W-1:0]   led_arr   [NUM_APPS];
    logic [31:0]        hex_arr   [NUM_APPS];

    sel_debouncer #(
        .WIDTH        (10),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sel_debouncer (
        .clk  (clk),
        .reset(reset),
        .din  (sel),
        .req  (req)
    );

    assign req_valid   = req < 10'(NUM_APPS);
    assign req_idx     = req[SEL_W-1:0];
    assign req_new     = req_valid && (req != 10'(active_q));
    assign frame_start = origin_q & ~origin_prev_q;
    assign active      = active_q;
    assign switching   = (state_q != StRun);

    // Split the flat application buses into per-app slices.
    always_comb begin
        for (int i = 0; i < NUM_APPS; i++) begin
            color_arr[i] = out_bus[slice_lo(i, COLOR_W) +: COLOR_W];
            led_arr[i]   = led_bus[slice_lo(i, LED_W) +: LED_W];
            hex_arr[i]   = hex_bus[slice_lo(i, 32) +: 32];
        end
    end

    // Register the origin condition so a held origin yields a single frame_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            origin_q      <= 1'b0;
            origin_prev_q <= 1'b0;
        end else begin
            origin_q      <= (x == 10'd0) && (y == 10'd0);
            origin_prev_q <= origin_q;
        end
    end

    // Switch FSM: request, wait for frame boundary, then blank for BLANK_FRAMES frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            active_q    <= '0;
            pending_q   <= '0;
            blank_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    // A request in the frame_start clock wins; the boundary is skipped.
                    if (req_new) begin
                        pending_q <= req_idx;
                        state_q   <= StWaitFrame;
                    end
                end
                StWaitFrame: begin
                    if (req_valid && !req_new) begin
                        state_q <= StRun;
                    end else if (frame_start) begin
                        active_q    <= req_new ? req_idx : pending_q;
                        pending_q   <= req_new ? req_idx : pending_q;
                        blank_cnt_q <= BlankW'(BLANK_FRAMES);
                        state_q     <= (BLANK_FRAMES == 0) ? StRun : StBlank;
                    end else if (req_new) begin
                        pending_q <= req_idx;
                    end
                end
                StBlank: begin
                    if (req_valid) begin
                        pending_q <= req_idx;
                    end
                    if (frame_start) begin
                        if (blank_cnt_q == BlankW'(1)) begin
                            blank_cnt_q <= '0;
                            state_q     <= StRun;
                        end else begin
                            blank_cnt_q <= blank_cnt_q - BlankW'(1);
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Registered output mux and per-app pause, one clock behind state and buses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out       <= '0;
            LED       <= '0;
            HEX0      <= HEX_OFF;
            HEX1      <= HEX_OFF;
            HEX2      <= HEX_OFF;
            HEX3      <= HEX_OFF;
            app_pause <= '1;
        end else begin
            LED <= led_arr[active_q];
            if (state_q == StBlank) begin
                out  <= '0;
                HEX0 <= HEX_OFF;
                HEX1 <= HEX_OFF;
                HEX2 <= HEX_OFF;
                HEX3 <= HEX_OFF;
            end else begin
                out  <= color_arr[active_q];
                HEX0 <= hex_arr[active_q][7:0];
                HEX1 <= hex_arr[active_q][15:8];
                HEX2 <= hex_arr[active_q][23:16];
                HEX3 <= hex_arr[active_q][31:24];
            end
            for (int i = 0; i < NUM_APPS; i++) begin
                app_pause[i] <= pause | (SEL_W'(i) != active_q) | (state_q == StBlank);
            end
        end
    end

endmodule

// File: tb/tb_app_switcher.sv
// Directed bench for app_switcher: 3 apps, 4-cycle debounce, 2 blank frames, 4x4 frames.
module tb_app_switcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        pause;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  sel;
    logic [35:0] out_bus = {12'h333, 12'h222, 12'h111};
    logic [29:0] led_bus = {10'h004, 10'h002, 10'h001};
    logic [95:0] hex_bus = {32'h23222120, 32'h13121110, 32'h03020100};
    logic [11:0] out;
    logic [9:0]  LED;
    logic [7:0]  HEX0;
    logic [7:0]  HEX1;
    logic [7:0]  HEX2;
    logic [7:0]  HEX3;
    logic [2:0]  app_pause;
    logic [1:0]  active;
    logic        switching;

    int checks = 0;
    int errors = 0;
    int pc     = 0;
    bit px_run = 1'b1;

    always #5 clk = ~clk;

    app_switcher #(
        .NUM_APPS     (3),
        .COLOR_W      (12),
        .LED_W        (10),
        .STABLE_CYCLES(4),
        .BLANK_FRAMES (2),
        .HEX_OFF      (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pause    (pause),
        .x        (x),
        .y        (y),
        .sel      (sel),
        .out_bus  (out_bus),
        .led_bus  (led_bus),
        .hex_bus  (hex_bus),
        .out      (out),
        .LED      (LED),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .app_pause(app_pause),
        .active   (active),
        .switching(switching)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; then, 1 unit after the edge, advance the 4x4 pixel raster.
    task automatic tick();
        @(posedge clk);
        #1;
        if (px_run) begin
            pc = (pc + 1) % 16;
            x  = 10'(pc % 4);
            y  = 10'(pc / 4);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic to_pc(input int n);
        for (int i = 0; i < 20 && pc != n; i++) tick();
        check("align_pc", 32'(pc), 32'(n));
    endtask

    initial begin
        reset = 1'b0;
        pause = 1'b0;
        sel   = 10'd0;
        x     = 10'd0;
        y     = 10'd0;

        // Reset state
        tick_n(3);
        check("rst_out", 32'(out), 32'h0);
        check("rst_led", 32'(LED), 32'h0);
        check("rst_hex0", 32'(HEX0), 32'hFF);
        check("rst_hex3", 32'(HEX3), 32'hFF);
        check("rst_pause", 32'(app_pause), 32'b111);
        check("rst_switching", 32'(switching), 32'h0);
        check("rst_active", 32'(active), 32'h0);

        reset = 1'b1;
        tick();
        check("rel_out", 32'(out), 32'h111);
        check("rel_led", 32'(LED), 32'h001);
        check("rel_hex0", 32'(HEX0), 32'h00);
        check("rel_hex3", 32'(HEX3), 32'h03);
        check("rel_pause", 32'(app_pause), 32'b110);

        // Asynchronous reset mid-stream
        tick_n(5);
        reset = 1'b0;
        #1;
        check("async_out", 32'(out), 32'h0);
        check("async_pause", 32'(app_pause), 32'b111);
        tick();
        reset = 1'b1;
        tick();
        check("rerel_out", 32'(out), 32'h111);
        check("rerel_active", 32'(active), 32'h0);

        // Switch 0 -> 2 with sel change on a frame origin clock (k = ticks since)
        to_pc(15);
        tick();
        sel = 10'd2;
        tick_n(6);
        check("sw_before_req", 32'(switching), 32'h0);
        tick();                                         // k=7
        check("sw_wait", 32'(switching), 32'h1);
        check("wait_active", 32'(active), 32'h0);
        check("wait_out", 32'(out), 32'h111);
        tick_n(10);                                     // k=17
        check("pre_frame_active", 32'(active), 32'h0);
        tick();                                         // k=18
        check("frame_active", 32'(active), 32'h2);
        tick();                                         // k=19
        check("blank_out", 32'(out), 32'h0);
        check("blank_hex0", 32'(HEX0), 32'hFF);
        check("blank_hex3", 32'(HEX3), 32'hFF);
        check("blank_led", 32'(LED), 32'h004);
        check("blank_pause", 32'(app_pause), 32'b111);
        tick_n(30);                                     // k=49
        check("blank2_out", 32'(out), 32'h0);
        check("blank2_sw", 32'(switching), 32'h1);
        tick();                                         // k=50
        check("run_sw", 32'(switching), 32'h0);
        tick();                                         // k=51
        check("run_out", 32'(out), 32'h333);
        check("run_hex0", 32'(HEX0), 32'h20);
        check("run_pause", 32'(app_pause), 32'b011);

        // Glitch to 1 for three clocks: never accepted
        sel = 10'd1;
        tick_n(3);
        sel = 10'd2;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_sw", 32'(switching), 32'h0);
        end
        check("glitch_active", 32'(active), 32'h2);

        // Invalid index ignored
        sel = 10'd5;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("inval_sw", 32'(switching), 32'h0);
        end
        check("inval_active", 32'(active), 32'h2);
        check("inval_out", 32'(out), 32'h333);

        // Cancel in WAIT_FRAME by returning to the active app
        to_pc(15);
        tick();
        sel = 10'd0;
        tick_n(7);                                      // k=7
        check("cancel_wait", 32'(switching), 32'h1);
        sel = 10'd2;
        tick_n(6);                                      // k=13
        check("cancel_still_wait", 32'(switching), 32'h1);
        tick();                                         // k=14
        check("cancel_run", 32'(switching), 32'h0);
        check("cancel_active", 32'(active), 32'h2);
        tick_n(6);                                      // k=20, past a frame boundary
        check("cancel_out", 32'(out), 32'h333);
        check("cancel_pause", 32'(app_pause), 32'b011);

        // Switch to 1, change to 2 during blank: sequence restarts after blank
        to_pc(15);
        tick();
        sel = 10'd1;
        tick_n(18);                                     // k=18
        check("rs_active1", 32'(active), 32'h1);
        check("rs_sw", 32'(switching), 32'h1);
        tick_n(2);                                      // k=20
        sel = 10'd2;
        tick_n(30);                                     // k=50
        check("rs_run", 32'(switching), 32'h0);
        check("rs_active_keep", 32'(active), 32'h1);
        tick();                                         // k=51
        check("rs_restart", 32'(switching), 32'h1);
        check("rs_out1", 32'(out), 32'h222);
        tick_n(15);                                     // k=66
        check("rs_active2", 32'(active), 32'h2);
        tick();                                         // k=67
        check("rs_blank_out", 32'(out), 32'h0);
        tick_n(31);                                     // k=98
        check("rs_done", 32'(switching), 32'h0);
        tick();                                         // k=99
        check("rs_out2", 32'(out), 32'h333);
        check("rs_pause", 32'(app_pause), 32'b011);

        // Global pause
        pause = 1'b1;
        tick();
        check("pause_all", 32'(app_pause), 32'b111);
        check("pause_out", 32'(out), 32'h333);
        pause = 1'b0;
        tick();
        check("unpause", 32'(app_pause), 32'b011);

        // Origin held for two clocks gives one frame_start
        px_run = 1'b0;
        x      = 10'd1;
        y      = 10'd1;
        sel    = 10'd0;
        tick_n(7);
        check("hold_wait", 32'(switching), 32'h1);
        x = 10'd0;
        y = 10'd0;
        tick_n(2);
        x = 10'd1;
        tick();
        check("hold_active", 32'(active), 32'h0);
        check("hold_blank", 32'(switching), 32'h1);
        x = 10'd0;
        tick();
        x = 10'd1;
        tick_n(2);
        check("one_frame_start", 32'(switching), 32'h1);
        x = 10'd0;
        tick();
        x = 10'd1;
        tick_n(2);
        check("hold_run", 32'(switching), 32'h0);
        tick();
        check("hold_out", 32'(out), 32'h111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
